// File: rtl/cdb_pkg.sv
// Shared CDB definitions: requester index map and the broadcast record seen by
// the reservation stations, register status table and ROB.
package cdb_pkg;
  localparam int CDB_NUM_REQ = 4;
  localparam int CDB_TAG_W   = 6;
  localparam int CDB_DATA_W  = 32;
  localparam int CDB_SRC_W   = $clog2(CDB_NUM_REQ);

  localparam int CDB_SRC_INT  = 0;
  localparam int CDB_SRC_MEM  = 1;
  localparam int CDB_SRC_MULT = 2;
  localparam int CDB_SRC_DIV  = 3;

  typedef struct packed {
    logic                  valid;
    logic [CDB_TAG_W-1:0]  tag;
    logic [CDB_DATA_W-1:0] data;
    logic [CDB_SRC_W-1:0]  src;
  } cdb_bcast_t;
endpackage

// File: rtl/cdb_bus_arbiter_rr_arbiter.sv
// Round-robin arbiter: one-hot grant scanning from rr_ptr, pointer moves past
// the winner when adv is high.
module rr_arbiter #(
  parameter int N = 4,
  localparam int W = (N > 1) ? $clog2(N) : 1
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic [N-1:0] req,
  input  logic         adv,
  output logic [N-1:0] grant,
  output logic [W-1:0] grant_idx
);
  logic [W-1:0] rr_ptr_q, rr_ptr_d;
  logic [W-1:0] pos;
  logic         found;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    pos       = '0;
    for (int k = 0; k < N; k++) begin
      pos = W'((int'(rr_ptr_q) + k) % N);
      if (!found && req[pos]) begin
        found      = 1'b1;
        grant[pos] = 1'b1;
        grant_idx  = pos;
      end
    end
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (adv && found) begin
      rr_ptr_d = (grant_idx == W'(N - 1)) ? '0 : W'(grant_idx + W'(1));
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) rr_ptr_q <= '0;
    else          rr_ptr_q <= rr_ptr_d;
  end
endmodule

// File: rtl/cdb_bus_arbiter.sv
// Common Data Bus arbiter: per-unit 1-entry holding buffers, round-robin
// selection, registered CDB broadcast.
module cdb_bus_arbiter
  import cdb_pkg::*;
#(
  parameter int NUM_REQ = CDB_NUM_REQ,
  parameter int TAG_W   = CDB_TAG_W,
  parameter int DATA_W  = CDB_DATA_W,
  parameter int SRC_W   = $clog2(NUM_REQ)
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic                      i_flush,
  input  logic [NUM_REQ-1:0]        i_req_valid,
  input  logic [NUM_REQ*TAG_W-1:0]  i_req_tag,
  input  logic [NUM_REQ*DATA_W-1:0] i_req_data,
  output logic [NUM_REQ-1:0]        o_req_ready,
  output logic                      o_cdb_valid,
  output logic [TAG_W-1:0]          o_cdb_tag,
  output logic [DATA_W-1:0]         o_cdb_data,
  output logic [SRC_W-1:0]          o_cdb_src
);
  logic [NUM_REQ-1:0] buf_valid_q, buf_valid_d;
  logic [TAG_W-1:0]   buf_tag_q  [NUM_REQ];
  logic [TAG_W-1:0]   buf_tag_d  [NUM_REQ];
  logic [DATA_W-1:0]  buf_data_q [NUM_REQ];
  logic [DATA_W-1:0]  buf_data_d [NUM_REQ];

  logic               cdb_valid_q, cdb_valid_d;
  logic [TAG_W-1:0]   cdb_tag_q, cdb_tag_d;
  logic [DATA_W-1:0]  cdb_data_q, cdb_data_d;
  logic [SRC_W-1:0]   cdb_src_q, cdb_src_d;

  logic [NUM_REQ-1:0] grant;
  logic [SRC_W-1:0]   grant_idx;
  logic [NUM_REQ-1:0] accept;

  // Flush suppresses the broadcast, so the pointer must not move either.
  rr_arbiter #(.N(NUM_REQ)) u_rr (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .req       (buf_valid_q),
    .adv       (~i_flush),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  assign o_req_ready = ~buf_valid_q | grant;
  assign accept      = i_req_valid & o_req_ready;

  always_comb begin
    buf_valid_d = buf_valid_q;
    buf_tag_d   = buf_tag_q;
    buf_data_d  = buf_data_q;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (accept[i]) begin
        buf_valid_d[i] = 1'b1;
        buf_tag_d[i]   = i_req_tag[i*TAG_W +: TAG_W];
        buf_data_d[i]  = i_req_data[i*DATA_W +: DATA_W];
      end else if (grant[i]) begin
        buf_valid_d[i] = 1'b0;
      end
    end
    if (i_flush) buf_valid_d = '0;
  end

  always_comb begin
    cdb_valid_d = 1'b0;
    cdb_tag_d   = cdb_tag_q;
    cdb_data_d  = cdb_data_q;
    cdb_src_d   = cdb_src_q;
    if (!i_flush && (|grant)) begin
      cdb_valid_d = 1'b1;
      cdb_tag_d   = buf_tag_q[grant_idx];
      cdb_data_d  = buf_data_q[grant_idx];
      cdb_src_d   = grant_idx;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      buf_valid_q <= '0;
      for (int i = 0; i < NUM_REQ; i++) begin
        buf_tag_q[i]  <= '0;
        buf_data_q[i] <= '0;
      end
      cdb_valid_q <= 1'b0;
      cdb_tag_q   <= '0;
      cdb_data_q  <= '0;
      cdb_src_q   <= '0;
    end else begin
      buf_valid_q <= buf_valid_d;
      buf_tag_q   <= buf_tag_d;
      buf_data_q  <= buf_data_d;
      cdb_valid_q <= cdb_valid_d;
      cdb_tag_q   <= cdb_tag_d;
      cdb_data_q  <= cdb_data_d;
      cdb_src_q   <= cdb_src_d;
    end
  end

  assign o_cdb_valid = cdb_valid_q;
  assign o_cdb_tag   = cdb_tag_q;
  assign o_cdb_data  = cdb_data_q;
  assign o_cdb_src   = cdb_src_q;
endmodule

// File: doc/cdb_bus_arbiter.md
Name: cdb_bus_arbiter

Overview:
- Shares the single Common Data Bus (CDB) among the out-of-order core's functional-unit result ports: int, mem, mult, div.
- Each requester has a 1-entry holding buffer; a round-robin arbiter selects one buffered result per cycle and drives it onto a registered CDB output.
- The CDB output feeds the reservation stations, register status table and ROB.
- Back-pressure goes to each unit through a per-requester ready signal.

Parameters:
- NUM_REQ, 4: number of result requesters. Fixed index map: 0=int, 1=mem, 2=mult, 3=div.
- TAG_W, 6: width of the ROB/rename tag broadcast with each result.
- DATA_W, 32: result data width.
- SRC_W, $clog2(NUM_REQ): width of the source-unit index.

Ports:
- i_clk  in  1  core clock; everything samples on the rising edge.
- i_rst_n  in  1  reset, asynchronous and active-low.
- i_flush  in  1  mispredict flush; discards buffered and pending results.
- i_req_valid  in  NUM_REQ  result valid, one bit per requester.
- i_req_tag  in  NUM_REQ*TAG_W  packed tags; requester i occupies bits [i*TAG_W +: TAG_W].
- i_req_data  in  NUM_REQ*DATA_W  packed result data, same packing.
- o_req_ready  out  NUM_REQ  requester i may present a result this cycle.
- o_cdb_valid  out  1  a CDB broadcast is valid this cycle.
- o_cdb_tag  out  TAG_W  tag being broadcast.
- o_cdb_data  out  DATA_W  data being broadcast.
- o_cdb_src  out  SRC_W  index of the unit that produced the broadcast.

Behaviour:
- Reset (asynchronous, i_rst_n=0):
  - buf_valid all 0; rr_ptr=0.
  - o_cdb_valid=0, o_cdb_tag=0, o_cdb_data=0, o_cdb_src=0.
  - o_req_ready all 1, since it is derived from empty buffers.
  - Reset asserted mid-transfer drops every buffered result with no broadcast.
- Holding buffer, per requester i:
  - Stores buf_valid, buf_tag, buf_data.
  - o_req_ready[i] = ~buf_valid[i] | grant[i]. This is combinational; grant depends only on buf_valid and rr_ptr, so there is no loop with i_req_valid.
  - Accept condition: i_req_valid[i] & o_req_ready[i]. On accept, the buffer loads tag/data at the edge and buf_valid stays or becomes 1.
  - Granted and not refilled: buf_valid goes to 0.
  - i_req_valid[i] while ready is low: the requester must hold tag/data stable. The arbiter ignores the request and the unit stalls.
- Arbitration (combinational over buf_valid):
  - grant is one-hot: the first i with buf_valid[i]=1, scanning rr_ptr, rr_ptr+1, ..., wrapping modulo NUM_REQ.
  - No buffer valid: grant=0 and rr_ptr holds.
  - After a grant to index g: rr_ptr <= (g+1) mod NUM_REQ. g=NUM_REQ-1 wraps to 0.
- CDB register:
  - Any grant: at the edge, o_cdb_valid<=1 and o_cdb_tag/data/src <= the granted buffer's contents.
  - No grant: o_cdb_valid<=0. tag/data/src hold their last value and are don't-care.
- Latency:
  - Uncontended: result presented in cycle N is on the CDB in cycle N+2 (buffer edge, then CDB edge).
  - Throughput: 1 broadcast per cycle.
  - The same requester can sustain 1 result per cycle when it is the only one requesting.
- Fairness:
  - With all NUM_REQ buffers continuously valid, each requester wins exactly once every NUM_REQ cycles.
  - No requester waits more than NUM_REQ-1 cycles after its buffer fills.
- Flush (i_flush=1, synchronous):
  - At the edge: all buf_valid<=0 and o_cdb_valid<=0. Flush has priority over accept and grant.
  - o_req_ready during the flush cycle follows the normal rule, but accepted data is discarded.
  - rr_ptr is unchanged.
- Simultaneous events:
  - Accept and grant on the same buffer in one cycle: the new result replaces the granted one and buf_valid stays 1.
  - All four requests arriving in one cycle are all accepted, because the buffers are empty.

Decomposition:
- Package cdb_pkg holds:
  - CDB_NUM_REQ, CDB_TAG_W, CDB_DATA_W.
  - Index constants CDB_SRC_INT=0, CDB_SRC_MEM=1, CDB_SRC_MULT=2, CDB_SRC_DIV=3.
  - typedef cdb_bcast_t, a struct {valid, tag, data, src} shared by the reservation stations and ROB.
- One sub-module, rr_arbiter:
  - Parameter N; inputs i_clk, i_rst_n, req[N], adv.
  - Outputs grant[N] (one-hot) and grant_idx.
  - Owns rr_ptr; the pointer advances when adv=1.
  - Buffers and the CDB register stay in the top module.

Test Plan:
1. Reset release, then i_req_valid[0]=1, tag=0x05, data=0xDEADBEEF for 1 cycle (cycle 1) -> o_cdb_valid=1, tag=0x05, data=0xDEADBEEF, src=0 in cycle 3. o_cdb_valid=0 in cycle 4.
2. Cycle 1: all 4 requesters valid, tags 0x10/0x11/0x12/0x13, rr_ptr=0 -> CDB shows src 0,1,2,3 in cycles 3,4,5,6. o_req_ready returns to all 1 by cycle 6.
3. Requester 2 continuously valid, tags 0x20, 0x21, ... every cycle, others idle -> one broadcast per cycle, tags in order, o_req_ready[2] never low.
4. Contention fairness: all four buffers kept full for 12 cycles -> each src broadcast exactly 3 times in strict rotation 0,1,2,3. Then starting with rr_ptr=3 -> first grant is 3, next is 0 (wrap).
5. Buffers 1 and 3 valid, i_flush=1 for one cycle -> next cycle o_cdb_valid=0, all o_req_ready=1, no broadcast of tags 1/3 ever. rr_ptr unchanged.
6. Asynchronous reset asserted mid-cycle while o_cdb_valid=1 -> o_cdb_valid=0 immediately, before the next clock edge. Pending buffers are lost; after release, the first grant goes to index 0.
